// File: rtl/sram_pkg.sv
// Shared types and constants for the async SRAM access controller.
package sram_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;
  localparam int WAIT_W  = 4;

  typedef logic [1:0] sram_be_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } sram_state_t;

  typedef struct packed {
    logic ce_n;
    logic ub_n;
    logic lb_n;
    logic oe_n;
    logic we_n;
  } sram_strb_t;

  localparam sram_strb_t STRB_IDLE = '{default: 1'b1};

  // Timer reload value: the state advances on the edge where the counter reads 0.
  function automatic logic [WAIT_W-1:0] wait_load(input int cycles);
    return WAIT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// CPU-side word request / response bus of the SRAM access controller.
interface sram_access_ctrl_if;
  import sram_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [SRAM_AW-1:0] req_addr;
  logic [SRAM_DW-1:0] req_wdata;
  sram_be_t           req_be;
  logic               rd_valid;
  logic [SRAM_DW-1:0] rd_data;
  logic               wr_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rd_valid, rd_data, wr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rd_valid, rd_data, wr_done
  );

endinterface

// File: rtl/sram_wait_timer.sv
// 4-bit load/decrement wait counter with a zero flag; saturates at 0.
module sram_wait_timer
  import sram_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_dec && (r_count != '0))
      r_count <= r_count - WAIT_W'(1);
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Bus master for the 16-bit async SRAM: turns CPU word requests into timed,
// fully registered CE/UB/LB/OE/WE strobe sequences and returns read data.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  sram_access_ctrl_if.slave   cpu,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                CE_N,
  output logic                UB_N,
  output logic                LB_N,
  output logic                OE_N,
  output logic                WE_N,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [SRAM_DW-1:0]  sram_dq_in
);

  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("sram_access_ctrl: RD_WAIT=%0d outside 1..15", RD_WAIT);
  end
  if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
    $error("sram_access_ctrl: WR_WAIT=%0d outside 1..15", WR_WAIT);
  end

  sram_state_t        r_state,    w_nxt_state;
  sram_strb_t         r_strb,     w_nxt_strb;
  logic [SRAM_AW-1:0] r_addr,     w_nxt_addr;
  logic [SRAM_DW-1:0] r_dq_out,   w_nxt_dq_out;
  logic               r_dq_oe,    w_nxt_dq_oe;
  logic [SRAM_DW-1:0] r_rd_data,  w_nxt_rd_data;
  logic               r_rd_valid, w_nxt_rd_valid;
  logic               r_wr_done,  w_nxt_wr_done;

  logic              w_tmr_load;
  logic [WAIT_W-1:0] w_tmr_load_val;
  logic              w_tmr_dec;
  logic              w_tmr_zero;

  sram_wait_timer u_wait_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_strb     <= STRB_IDLE;
      r_addr     <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_strb     <= w_nxt_strb;
      r_addr     <= w_nxt_addr;
      r_dq_out   <= w_nxt_dq_out;
      r_dq_oe    <= w_nxt_dq_oe;
      r_rd_data  <= w_nxt_rd_data;
      r_rd_valid <= w_nxt_rd_valid;
      r_wr_done  <= w_nxt_wr_done;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_strb     = r_strb;
    w_nxt_addr     = r_addr;
    w_nxt_dq_out   = r_dq_out;
    w_nxt_dq_oe    = r_dq_oe;
    w_nxt_rd_data  = r_rd_data;
    w_nxt_rd_valid = 1'b0;
    w_nxt_wr_done  = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_dec      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (cpu.req_valid) begin
          w_nxt_addr      = cpu.req_addr;
          w_nxt_strb.ce_n = 1'b0;
          if (cpu.req_we) begin
            w_nxt_state     = S_WR_SETUP;
            w_nxt_strb.ub_n = ~cpu.req_be[1];
            w_nxt_strb.lb_n = ~cpu.req_be[0];
            w_nxt_strb.oe_n = 1'b1;
            w_nxt_strb.we_n = 1'b1;
            w_nxt_dq_out    = cpu.req_wdata;
            w_nxt_dq_oe     = 1'b1;
          end else begin
            // Reads always fetch the full word; byte enables are ignored.
            w_nxt_state     = S_RD;
            w_nxt_strb.ub_n = 1'b0;
            w_nxt_strb.lb_n = 1'b0;
            w_nxt_strb.oe_n = 1'b0;
            w_tmr_load      = 1'b1;
            w_tmr_load_val  = wait_load(RD_WAIT);
          end
        end
      end

      S_RD: begin
        if (w_tmr_zero) begin
          w_nxt_state    = S_IDLE;
          w_nxt_strb     = STRB_IDLE;
          w_nxt_rd_data  = sram_dq_in;
          w_nxt_rd_valid = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      S_WR_SETUP: begin
        w_nxt_state     = S_WR_PULSE;
        w_nxt_strb.we_n = 1'b0;
        w_tmr_load      = 1'b1;
        w_tmr_load_val  = wait_load(WR_WAIT);
      end

      S_WR_PULSE: begin
        if (w_tmr_zero) begin
          w_nxt_state     = S_WR_HOLD;
          w_nxt_strb.we_n = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      S_WR_HOLD: begin
        w_nxt_state   = S_IDLE;
        w_nxt_strb    = STRB_IDLE;
        w_nxt_dq_oe   = 1'b0;
        w_nxt_wr_done = 1'b1;
      end

      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_strb  = STRB_IDLE;
        w_nxt_dq_oe = 1'b0;
      end
    endcase
  end

  assign cpu.req_ready = (r_state == S_IDLE);
  assign cpu.rd_valid  = r_rd_valid;
  assign cpu.rd_data   = r_rd_data;
  assign cpu.wr_done   = r_wr_done;

  assign SRAM_ADDR   = r_addr;
  assign CE_N        = r_strb.ce_n;
  assign UB_N        = r_strb.ub_n;
  assign LB_N        = r_strb.lb_n;
  assign OE_N        = r_strb.oe_n;
  assign WE_N        = r_strb.we_n;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: one instance at RD/WR_WAIT=2/2, one at 1/15,
// each with a small byte-lane SRAM model.
module tb_sram_access_ctrl;
  import sram_pkg::*;

  localparam int A_RD = 2, A_WR = 2;
  localparam int B_RD = 1, B_WR = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Shared stimulus, steered to one instance by sel.
  logic        sel;
  logic        req_valid, req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  sram_access_ctrl_if if_a ();
  sram_access_ctrl_if if_b ();

  assign if_a.req_valid = req_valid & ~sel;
  assign if_a.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_a.req_be    = req_be;
  assign if_b.req_valid = req_valid & sel;
  assign if_b.req_we    = req_we;
  assign if_b.req_addr  = req_addr;
  assign if_b.req_wdata = req_wdata;
  assign if_b.req_be    = req_be;

  logic [19:0] a_addr, b_addr;
  logic        a_ce_n, a_ub_n, a_lb_n, a_oe_n, a_we_n, a_dq_oe;
  logic        b_ce_n, b_ub_n, b_lb_n, b_oe_n, b_we_n, b_dq_oe;
  logic [15:0] a_dq_out, a_dq_in, b_dq_out, b_dq_in;

  sram_access_ctrl #(.RD_WAIT(A_RD), .WR_WAIT(A_WR)) dut_a (
    .Clk(clk), .Reset(rst), .cpu(if_a), .SRAM_ADDR(a_addr),
    .CE_N(a_ce_n), .UB_N(a_ub_n), .LB_N(a_lb_n), .OE_N(a_oe_n), .WE_N(a_we_n),
    .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_dq_in(a_dq_in)
  );

  sram_access_ctrl #(.RD_WAIT(B_RD), .WR_WAIT(B_WR)) dut_b (
    .Clk(clk), .Reset(rst), .cpu(if_b), .SRAM_ADDR(b_addr),
    .CE_N(b_ce_n), .UB_N(b_ub_n), .LB_N(b_lb_n), .OE_N(b_oe_n), .WE_N(b_we_n),
    .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in)
  );

  // SRAM models: byte-lane writes while CE/WE are low, combinational reads while CE/OE are low.
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= '0;
    end else if (!a_ce_n && !a_we_n && a_dq_oe) begin
      if (!a_ub_n) mem_a[a_addr[7:0]][15:8] <= a_dq_out[15:8];
      if (!a_lb_n) mem_a[a_addr[7:0]][7:0]  <= a_dq_out[7:0];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= '0;
    end else if (!b_ce_n && !b_we_n && b_dq_oe) begin
      if (!b_ub_n) mem_b[b_addr[7:0]][15:8] <= b_dq_out[15:8];
      if (!b_lb_n) mem_b[b_addr[7:0]][7:0]  <= b_dq_out[7:0];
    end
  end

  assign a_dq_in = (!a_ce_n && !a_oe_n) ? mem_a[a_addr[7:0]] : 16'hDEAD;
  assign b_dq_in = (!b_ce_n && !b_oe_n) ? mem_b[b_addr[7:0]] : 16'hDEAD;

  // Bus contention monitor: OE_N low while the controller drives DQ.
  int ovl_cnt = 0;
  always @(negedge clk) begin
    if (!rst && ((!a_oe_n && a_dq_oe) || (!b_oe_n && b_dq_oe))) ovl_cnt++;
  end

  // Observation mux following sel.
  logic        m_ready, m_rd_valid, m_wr_done, m_dq_oe;
  logic [15:0] m_rd_data, m_dq_out;
  logic [19:0] m_addr;
  logic [4:0]  m_strb;
  assign m_ready    = sel ? if_b.req_ready : if_a.req_ready;
  assign m_rd_valid = sel ? if_b.rd_valid  : if_a.rd_valid;
  assign m_wr_done  = sel ? if_b.wr_done   : if_a.wr_done;
  assign m_rd_data  = sel ? if_b.rd_data   : if_a.rd_data;
  assign m_addr     = sel ? b_addr         : a_addr;
  assign m_dq_oe    = sel ? b_dq_oe        : a_dq_oe;
  assign m_dq_out   = sel ? b_dq_out       : a_dq_out;
  assign m_strb     = sel ? {b_ce_n, b_ub_n, b_lb_n, b_oe_n, b_we_n}
                          : {a_ce_n, a_ub_n, a_lb_n, a_oe_n, a_we_n};

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;

  // Issue one request from an idle, post-edge point; sample k=0 is the cycle after the accept edge.
  // Expected: read done at k=rd_wait with OE_N low rd_wait cycles; write done at k=wr_wait+2 with
  // WE_N low wr_wait cycles and dq_oe high wr_wait+2 cycles.
  task automatic do_op(input string tag, input vec_t v, input int rd_wait, input int wr_wait);
    int done_k = -1;
    int we_lo = 0, oe_lo = 0, dq_hi = 0, addr_bad = 0, lane_bad = 0, busy_rdy = 0, data_bad = 0;
    logic got_rv = 1'b0, got_wd = 1'b0;
    logic exp_ub, exp_lb;
    exp_ub = v.we ? ~v.be[1] : 1'b0;
    exp_lb = v.we ? ~v.be[0] : 1'b0;
    check({tag, "_ready_before"}, {31'd0, m_ready}, 32'd1);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_be = ~v.be;
    for (int k = 0; k < 40; k++) begin
      if (m_rd_valid || m_wr_done) begin
        done_k = k; got_rv = m_rd_valid; got_wd = m_wr_done;
        break;
      end
      if (!m_strb[0]) we_lo++;
      if (!m_strb[1]) oe_lo++;
      if (m_dq_oe) dq_hi++;
      if (m_addr !== v.addr || m_strb[4] !== 1'b0) addr_bad++;
      if (m_strb[3] !== exp_ub || m_strb[2] !== exp_lb) lane_bad++;
      if (v.we && m_dq_out !== v.wdata) data_bad++;
      if (m_ready) busy_rdy++;
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, done_k, v.we ? wr_wait + 2 : rd_wait);
    check({tag, "_pulse_kind"}, {30'd0, got_rv, got_wd}, v.we ? 32'd1 : 32'd2);
    check({tag, "_we_low_cycles"}, we_lo, v.we ? wr_wait : 0);
    check({tag, "_oe_low_cycles"}, oe_lo, v.we ? 0 : rd_wait);
    check({tag, "_dq_oe_cycles"}, dq_hi, v.we ? wr_wait + 2 : 0);
    check({tag, "_addr_ce_bad"}, addr_bad, 0);
    check({tag, "_byte_lane_bad"}, lane_bad, 0);
    if (v.we) check({tag, "_wdata_hold_bad"}, data_bad, 0);
    check({tag, "_ready_while_busy"}, busy_rdy, 0);
    check({tag, "_idle_strobes"}, {27'd0, m_strb}, 32'h1F);
    check({tag, "_idle_dq_oe"}, {31'd0, m_dq_oe}, 32'd0);
    if (!v.we) check({tag, "_rd_data"}, {16'd0, m_rd_data}, {16'd0, v.exp_rd});
    @(posedge clk); #1;
    check({tag, "_pulse_cleared"}, {30'd0, m_rd_valid, m_wr_done}, 32'd0);
    if (!v.we) check({tag, "_rd_data_held"}, {16'd0, m_rd_data}, {16'd0, v.exp_rd});
  endtask

  vec_t vec_a [10];
  vec_t vec_b [2];

  initial begin
    int seen;
    int bad;

    vec_a[0] = '{1'b1, 20'h00ABC, 16'hBEEF, 2'b11, 16'h0000};
    vec_a[1] = '{1'b0, 20'h00ABC, 16'h0000, 2'b00, 16'hBEEF};
    vec_a[2] = '{1'b1, 20'h00ABC, 16'h1234, 2'b01, 16'h0000};
    vec_a[3] = '{1'b0, 20'h00ABC, 16'h0000, 2'b11, 16'hBE34};
    vec_a[4] = '{1'b1, 20'h00ABD, 16'hAAAA, 2'b11, 16'h0000};
    vec_a[5] = '{1'b1, 20'h00ABD, 16'h5555, 2'b00, 16'h0000};
    vec_a[6] = '{1'b0, 20'h00ABD, 16'h0000, 2'b10, 16'hAAAA};
    vec_a[7] = '{1'b1, 20'h00ABD, 16'h77C3, 2'b10, 16'h0000};
    vec_a[8] = '{1'b0, 20'h00ABD, 16'h0000, 2'b00, 16'h77AA};
    vec_a[9] = '{1'b0, 20'h00000, 16'h0000, 2'b00, 16'h0000};
    vec_b[0] = '{1'b1, 20'h00010, 16'h1357, 2'b11, 16'h0000};
    vec_b[1] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'h1357};

    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ready",    {31'd0, m_ready},    32'd1);
    check("rst_rd_valid", {31'd0, m_rd_valid}, 32'd0);
    check("rst_wr_done",  {31'd0, m_wr_done},  32'd0);
    check("rst_rd_data",  {16'd0, m_rd_data},  32'd0);
    check("rst_addr",     {12'd0, m_addr},     32'd0);
    check("rst_strobes",  {27'd0, m_strb},     32'h1F);
    check("rst_dq_oe",    {31'd0, m_dq_oe},    32'd0);
    check("rst_dq_out",   {16'd0, m_dq_out},   32'd0);
    sel = 1'b1; #1;
    check("rst_b_strobes", {27'd0, m_strb}, 32'h1F);
    check("rst_b_ready",   {31'd0, m_ready}, 32'd1);
    sel = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of the WE_N pulse aborts the write silently
    req_we = 1'b1; req_addr = 20'h00120; req_wdata = 16'hFACE; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_we_low_before_reset", {31'd0, m_strb[0]}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_strobes", {27'd0, m_strb},     32'h1F);
    check("abort_dq_oe",   {31'd0, m_dq_oe},    32'd0);
    check("abort_ready",   {31'd0, m_ready},    32'd1);
    check("abort_wr_done", {31'd0, m_wr_done},  32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_wr_done || m_rd_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_late_pulse", seen, 0);

    // Table vectors on the 2/2 instance
    for (int i = 0; i < 10; i++) do_op($sformatf("a%0d", i), vec_a[i], A_RD, A_WR);
    check("model_be01_word", {16'd0, mem_a[8'hBC]}, 32'h0000BE34);
    check("model_be10_word", {16'd0, mem_a[8'hBD]}, 32'h000077AA);

    // Read held valid, write presented in the rd_valid cycle: accepted with no idle gap
    req_we = 1'b0; req_addr = 20'h00ABC; req_be = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_rd_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("b2b_rd_valid_seen", seen, 1);
    check("b2b_rd_data", {16'd0, m_rd_data}, 32'h0000BE34);
    check("b2b_ready_in_rd_valid", {31'd0, m_ready}, 32'd1);
    req_we = 1'b1; req_addr = 20'h00ABE; req_wdata = 16'hC0DE; req_be = 2'b11;
    @(posedge clk); #1 req_valid = 1'b0;
    check("b2b_wr_dq_oe", {31'd0, m_dq_oe}, 32'd1);
    check("b2b_wr_strobes", {27'd0, m_strb}, 32'h03);
    check("b2b_wr_addr", {12'd0, m_addr}, 32'h00ABE);
    check("b2b_ready_busy", {31'd0, m_ready}, 32'd0);
    check("b2b_rd_data_held", {16'd0, m_rd_data}, 32'h0000BE34);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_wr_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("b2b_wr_done_seen", seen, 1);
    @(posedge clk); #1;
    do_op("b2b_readback", '{1'b0, 20'h00ABE, 16'h0000, 2'b11, 16'hC0DE}, A_RD, A_WR);

    // RD_WAIT=1 / WR_WAIT=15 instance
    sel = 1'b1; #1;
    for (int i = 0; i < 2; i++) do_op($sformatf("b%0d", i), vec_b[i], B_RD, B_WR);

    // A one-cycle read request while the long write is busy must be dropped
    req_we = 1'b1; req_addr = 20'h00030; req_wdata = 16'h2468; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    req_we = 1'b0; req_addr = 20'h00010; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_wr_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("busy_wr_done_seen", seen, 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (!m_strb[1] || m_rd_valid || !m_ready) bad++;
    end
    check("busy_pulse_ignored", bad, 0);
    check("busy_model_word", {16'd0, mem_b[8'h30]}, 32'h00002468);

    check("no_oe_dq_overlap", ovl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
